// File: rtl/pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter: default sizes and
// FSM state encoding, also used by bench-side monitors.
package pattern_tx_pkg;

    localparam int unsigned PW_DEF  = 4;
    localparam int unsigned CW_DEF  = 4;
    localparam int unsigned GAP_DEF = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_SEND = ST_SEND,
        S_GAP  = ST_GAP,
        S_DONE = ST_DONE
    } state_e;

endpackage

// File: rtl/pattern_ser_tx.sv
// Serial pattern transmitter: sends a programmable pattern MSB-first, repeated
// count times, either back-to-back or separated by GAP idle bit-times.
module pattern_ser_tx
    import pattern_tx_pkg::*;
#(
    parameter int unsigned PW  = PW_DEF,
    parameter int unsigned CW  = CW_DEF,
    parameter int unsigned GAP = GAP_DEF
) (
    input  logic          clock,
    input  logic          rst,
    input  logic [PW-1:0] pattern,
    input  logic          p_load,
    input  logic          overlap,
    input  logic          o_load,
    input  logic [CW-1:0] count,
    input  logic          start,
    output logic          ser_out,
    output logic          valid,
    output logic          mark,
    output logic          busy,
    output logic          done
);

    localparam int unsigned IW = (PW > 1) ? $clog2(PW) : 1;
    localparam int unsigned GW = $clog2(GAP + 1);

    state_e         r_state;
    logic [PW-1:0]  r_pat;
    logic           r_ovl;
    logic [IW-1:0]  r_idx;
    logic [CW-1:0]  r_reps;
    logic [GW-1:0]  r_gap;

    state_e         w_state_next;
    logic [IW-1:0]  w_idx_next;
    logic [CW-1:0]  w_reps_next;
    logic [GW-1:0]  w_gap_next;
    logic           w_cfg_en;

    // Configuration may only change between frames.
    assign w_cfg_en = (r_state == S_IDLE) || (r_state == S_DONE);

    // State and counter registers.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pat   <= '0;
            r_ovl   <= 1'b0;
            r_idx   <= IW'(PW - 1);
            r_reps  <= '0;
            r_gap   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_reps  <= w_reps_next;
            r_gap   <= w_gap_next;
            if (w_cfg_en && p_load) begin
                r_pat <= pattern;
            end
            if (w_cfg_en && o_load) begin
                r_ovl <= overlap;
            end
        end
    end

    // Next-state and counter update.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_reps_next  = r_reps;
        w_gap_next   = r_gap;
        case (r_state)
            S_IDLE, S_DONE: begin
                w_state_next = S_IDLE;
                if (start) begin
                    if (count != '0) begin
                        w_reps_next  = count;
                        w_idx_next   = IW'(PW - 1);
                        w_state_next = S_SEND;
                    end else begin
                        w_state_next = S_DONE;
                    end
                end
            end
            S_SEND: begin
                if (r_idx != '0) begin
                    w_idx_next = r_idx - IW'(1);
                end else begin
                    w_idx_next = IW'(PW - 1);
                    if (r_reps > CW'(1)) begin
                        w_reps_next = r_reps - CW'(1);
                        if (r_ovl) begin
                            w_state_next = S_SEND;
                        end else begin
                            w_state_next = S_GAP;
                            w_gap_next   = GW'(GAP - 1);
                        end
                    end else begin
                        w_state_next = S_DONE;
                    end
                end
            end
            S_GAP: begin
                if (r_gap != '0) begin
                    w_gap_next = r_gap - GW'(1);
                end else begin
                    w_state_next = S_SEND;
                    w_idx_next   = IW'(PW - 1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Outputs decoded purely from registered state.
    always_comb begin
        ser_out = 1'b0;
        valid   = 1'b0;
        mark    = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (r_state)
            S_SEND: begin
                ser_out = r_pat[r_idx];
                valid   = 1'b1;
                busy    = 1'b1;
                mark    = (r_idx == '0);
            end
            S_GAP: begin
                busy = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_pattern_ser_tx.sv
// Scoreboard bench for pattern_ser_tx: a cycle-level model queues expected
// output tuples, and a negedge monitor pops and compares them.
module tb_pattern_ser_tx;
    import pattern_tx_pkg::*;

    localparam int unsigned PW  = 4;
    localparam int unsigned CW  = 4;
    localparam int unsigned GAP = 2;

    typedef struct packed {
        logic ser;
        logic val;
        logic mrk;
        logic bsy;
        logic dn;
    } exp_t;

    logic          clock;
    logic          rst;
    logic [PW-1:0] pattern;
    logic          p_load;
    logic          overlap;
    logic          o_load;
    logic [CW-1:0] count;
    logic          start;
    logic          ser_out;
    logic          valid;
    logic          mark;
    logic          busy;
    logic          done;

    exp_t          sb_q[$];
    int            n_vec = 0;
    int            n_err = 0;
    string         cur_test = "init";
    logic [PW-1:0] m_pat = '0;
    logic          m_ovl = 1'b0;

    pattern_ser_tx #(.PW(PW), .CW(CW), .GAP(GAP)) dut (
        .clock   (clock),
        .rst     (rst),
        .pattern (pattern),
        .p_load  (p_load),
        .overlap (overlap),
        .o_load  (o_load),
        .count   (count),
        .start   (start),
        .ser_out (ser_out),
        .valid   (valid),
        .mark    (mark),
        .busy    (busy),
        .done    (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Monitor: one expected tuple per cycle while the scoreboard holds entries.
    always @(negedge clock) begin
        if (sb_q.size() != 0) begin
            exp_t e;
            exp_t got;
            e   = sb_q.pop_front();
            got = {ser_out, valid, mark, busy, done};
            n_vec++;
            if (got !== e) begin
                n_err++;
                $display("FAIL %s: {ser,valid,mark,busy,done} got %b required %b at %0t",
                         cur_test, got, e, $time);
            end
        end
    end

    function automatic void push_idle(input int n);
        for (int i = 0; i < n; i++) sb_q.push_back(exp_t'(5'b00000));
    endfunction

    // Reference model of one frame, including the trailing done cycle.
    function automatic void push_frame(input logic [PW-1:0] pat, input logic ovl,
                                       input int cnt);
        for (int r = 0; r < cnt; r++) begin
            for (int b = PW - 1; b >= 0; b--) begin
                sb_q.push_back({pat[b], 1'b1, (b == 0), 1'b1, 1'b0});
            end
            if (!ovl && (r != cnt - 1)) begin
                for (int g = 0; g < GAP; g++) sb_q.push_back(exp_t'(5'b00010));
            end
        end
        sb_q.push_back(exp_t'(5'b00001));
    endfunction

    task automatic wait_drain();
        int cyc = 0;
        while (sb_q.size() != 0 && cyc < 400) begin
            @(posedge clock);
            cyc++;
        end
        #1;
        if (sb_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s drain: %0d entries left, required 0", cur_test, sb_q.size());
            sb_q.delete();
        end
    endtask

    // Called at posedge+1 with the DUT idle; returns with the first bit on the line.
    task automatic start_frame(input logic [PW-1:0] pat, input logic do_pl,
                               input logic ovl, input logic do_ol, input int cnt);
        push_idle(1);
        pattern = pat;
        p_load  = do_pl;
        overlap = ovl;
        o_load  = do_ol;
        count   = CW'(cnt);
        start   = 1'b1;
        if (do_pl) m_pat = pat;
        if (do_ol) m_ovl = ovl;
        push_frame(m_pat, m_ovl, cnt);
        @(posedge clock);
        #1;
        p_load = 1'b0;
        o_load = 1'b0;
        start  = 1'b0;
    endtask

    task automatic finish_frame();
        wait_drain();
        push_idle(1);
        wait_drain();
    endtask

    task automatic test_reset();
        cur_test = "reset";
        rst = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        n_vec++;
        if ({ser_out, valid, mark, busy, done} !== 5'b00000) begin
            n_err++;
            $display("FAIL reset_outputs: got %b required 00000",
                     {ser_out, valid, mark, busy, done});
        end
        n_vec++;
        if (dut.r_state !== ST_IDLE) begin
            n_err++;
            $display("FAIL reset_state: got %b required %b", dut.r_state, ST_IDLE);
        end
        rst = 1'b0;
        m_pat = '0;
        m_ovl = 1'b0;
        push_idle(2);
        wait_drain();
    endtask

    task automatic test_overlap();
        cur_test = "overlap";
        start_frame(4'b1010, 1'b1, 1'b1, 1'b1, 2);
        finish_frame();
    endtask

    task automatic test_non_overlap();
        cur_test = "non_overlap";
        start_frame(4'b1010, 1'b1, 1'b0, 1'b1, 2);
        finish_frame();
    endtask

    task automatic test_zero_count();
        cur_test = "zero_count";
        start_frame(4'b1111, 1'b0, 1'b0, 1'b0, 0);
        finish_frame();
    endtask

    task automatic test_load_while_busy();
        cur_test = "load_while_busy";
        start_frame(4'b0101, 1'b1, 1'b1, 1'b1, 2);
        @(posedge clock);
        #1;
        pattern = 4'b1111;
        p_load  = 1'b1;
        overlap = 1'b0;
        o_load  = 1'b1;
        count   = 4'd5;
        start   = 1'b1;
        @(posedge clock);
        #1;
        p_load = 1'b0;
        o_load = 1'b0;
        start  = 1'b0;
        finish_frame();
        cur_test = "load_ignored_next";
        start_frame(4'b1111, 1'b0, 1'b0, 1'b0, 2);
        finish_frame();
        cur_test = "load_in_idle";
        start_frame(4'b1111, 1'b1, 1'b1, 1'b0, 1);
        finish_frame();
    endtask

    task automatic test_reset_mid();
        cur_test = "reset_mid";
        start_frame(4'b1011, 1'b1, 1'b1, 1'b1, 3);
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        rst = 1'b1;
        @(negedge clock);
        #1;
        sb_q.delete();
        m_pat = '0;
        m_ovl = 1'b0;
        push_idle(3);
        @(posedge clock);
        #1;
        rst = 1'b0;
        wait_drain();
        cur_test = "after_reset";
        start_frame(4'b1111, 1'b0, 1'b1, 1'b0, 2);
        finish_frame();
    endtask

    task automatic test_back_to_back();
        cur_test = "back_to_back";
        start_frame(4'b1100, 1'b1, 1'b1, 1'b1, 1);
        repeat (PW) begin
            @(posedge clock);
            #1;
        end
        start = 1'b1;
        count = 4'd1;
        push_frame(m_pat, m_ovl, 1);
        @(posedge clock);
        #1;
        start = 1'b0;
        finish_frame();
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            logic [PW-1:0] pat;
            logic          ovl;
            int            cnt;
            cur_test = $sformatf("random%0d", i);
            pat = PW'($urandom);
            ovl = 1'($urandom_range(0, 1));
            cnt = (i == 0) ? 15 : int'($urandom_range(0, 4));
            start_frame(pat, 1'b1, ovl, 1'b1, cnt);
            finish_frame();
        end
    endtask

    initial begin
        rst     = 1'b1;
        pattern = '0;
        p_load  = 1'b0;
        overlap = 1'b0;
        o_load  = 1'b0;
        count   = '0;
        start   = 1'b0;
        test_reset();
        test_overlap();
        test_non_overlap();
        test_zero_count();
        test_load_while_busy();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
